// File: rtl/codificador_quadrante_botoes_pkg.sv
// Shared definitions for the quadrant path: FSM state codes, the "no quadrant"
// code and a one-hot test used by the button encoder.
package codificador_quadrante_botoes_pkg;

  typedef enum logic [2:0] {
    ESPERA     = 3'd0,
    ESTABILIZA = 3'd1,
    DECIDE     = 3'd2,
    SOLTAR     = 3'd3
  } estado_t;

  localparam logic [8:0] QUADRANTE_NENHUM = 9'b0;

  // Exactly one bit set: non-zero and clearing the lowest set bit leaves zero.
  function automatic logic eh_um_quente(input logic [8:0] v);
    return (v != 9'd0) && ((v & (v - 9'd1)) == 9'd0);
  endfunction

endpackage

// File: rtl/codificador_quadrante_botoes_sincronizador_2ff.sv
// Two-flop synchronizer of configurable width for asynchronous inputs,
// cleared by the synchronous reset.
module sincronizador_2ff #(
  parameter int LARGURA = 1
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [LARGURA-1:0] d,
  output logic [LARGURA-1:0] q
);

  logic [LARGURA-1:0] estagio1_q;
  logic [LARGURA-1:0] estagio2_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      estagio1_q <= '0;
      estagio2_q <= '0;
    end else begin
      estagio1_q <= d;
      estagio2_q <= estagio1_q;
    end
  end

  assign q = estagio2_q;

endmodule

// File: rtl/codificador_quadrante_botoes.sv
// Turns the nine raw quadrant buttons into a registered one-hot quadrant code,
// with synchronization, press/release debounce and multi-press rejection.
module codificador_quadrante_botoes
  import codificador_quadrante_botoes_pkg::*;
#(
  parameter int DEBOUNCE_CICLOS = 50000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [8:0] botoes,
  input  logic       habilita,
  input  logic       limpa,
  output logic [8:0] quadrante,
  output logic       pronto,
  output logic       erro,
  output logic [2:0] db_estado
);

  localparam int CW = $clog2(DEBOUNCE_CICLOS);
  localparam logic [CW-1:0] CONT_MAX = CW'(DEBOUNCE_CICLOS - 1);

  logic [8:0]    sinc;
  estado_t       estado_q, estado_d;
  logic [CW-1:0] contador_q, contador_d;
  logic [8:0]    amostra_q, amostra_d;
  logic [8:0]    quadrante_q, quadrante_d;
  logic          pronto_q, pronto_d;
  logic          erro_q, erro_d;

  sincronizador_2ff #(.LARGURA(9)) u_sinc (
    .clock (clock),
    .reset (reset),
    .d     (botoes),
    .q     (sinc)
  );

  always_comb begin
    estado_d    = estado_q;
    contador_d  = contador_q;
    amostra_d   = amostra_q;
    quadrante_d = limpa ? QUADRANTE_NENHUM : quadrante_q;
    pronto_d    = 1'b0;
    erro_d      = 1'b0;

    case (estado_q)
      ESPERA: begin
        if (sinc != 9'd0) begin
          amostra_d  = sinc;
          contador_d = '0;
          estado_d   = ESTABILIZA;
        end
      end
      ESTABILIZA: begin
        if (sinc == 9'd0) begin
          estado_d   = ESPERA;
          contador_d = '0;
        end else if (sinc != amostra_q) begin
          amostra_d  = sinc;
          contador_d = '0;
        end else if (contador_q == CONT_MAX) begin
          estado_d   = DECIDE;
          contador_d = '0;
        end else begin
          contador_d = contador_q + CW'(1);
        end
      end
      DECIDE: begin
        estado_d   = SOLTAR;
        contador_d = '0;
        // A load here overrides a coincident limpa.
        if (eh_um_quente(amostra_q)) begin
          if (habilita) begin
            quadrante_d = amostra_q;
            pronto_d    = 1'b1;
          end
        end else begin
          erro_d = 1'b1;
        end
      end
      SOLTAR: begin
        // Any activity restarts the release window, so no new press slips in.
        if (sinc != 9'd0) begin
          contador_d = '0;
        end else if (contador_q == CONT_MAX) begin
          estado_d   = ESPERA;
          contador_d = '0;
        end else begin
          contador_d = contador_q + CW'(1);
        end
      end
      default: begin
        estado_d   = ESPERA;
        contador_d = '0;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      estado_q    <= ESPERA;
      contador_q  <= '0;
      amostra_q   <= 9'd0;
      quadrante_q <= QUADRANTE_NENHUM;
      pronto_q    <= 1'b0;
      erro_q      <= 1'b0;
    end else begin
      estado_q    <= estado_d;
      contador_q  <= contador_d;
      amostra_q   <= amostra_d;
      quadrante_q <= quadrante_d;
      pronto_q    <= pronto_d;
      erro_q      <= erro_d;
    end
  end

  assign quadrante = quadrante_q;
  assign pronto    = pronto_q;
  assign erro      = erro_q;
  assign db_estado = estado_q;

endmodule

// File: tb/tb_codificador_quadrante_botoes.sv
// Bench for the quadrant button encoder: directed scenarios plus random button
// activity, compared every cycle against a run-length model of the debouncer.
module tb_codificador_quadrante_botoes;
  import codificador_quadrante_botoes_pkg::*;

  localparam int D = 4;

  logic       clock = 1'b0;
  logic       reset;
  logic [8:0] botoes;
  logic       habilita;
  logic       limpa;
  logic [8:0] quadrante;
  logic       pronto;
  logic       erro;
  logic [2:0] db_estado;

  int total = 0;
  int bad   = 0;
  int n_pronto = 0;
  int n_erro   = 0;
  int ciclo    = 0;

  // Behavioural model: two-cycle input delay, then run lengths of the
  // synchronized value decide presses and releases.
  logic [8:0] m_s1, m_s2, m_run_val, m_quad, m_obs;
  int         m_run_len, m_zero_len;
  bit         m_pending, m_blocked, m_pronto, m_erro, m_load;
  logic [2:0] m_estado;

  codificador_quadrante_botoes #(.DEBOUNCE_CICLOS(D)) dut (
    .clock     (clock),
    .reset     (reset),
    .botoes    (botoes),
    .habilita  (habilita),
    .limpa     (limpa),
    .quadrante (quadrante),
    .pronto    (pronto),
    .erro      (erro),
    .db_estado (db_estado)
  );

  always #5 clock = ~clock;

  task automatic check(input string nome, input logic [31:0] atual, input logic [31:0] esperado);
    total++;
    if (atual !== esperado) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h (cycle %0d)", nome, atual, esperado, ciclo);
    end
  endtask

  task automatic modelo_passo();
    if (reset) begin
      m_s1 = 0; m_s2 = 0; m_run_val = 0; m_quad = 0;
      m_run_len = 0; m_zero_len = 0;
      m_pending = 0; m_blocked = 0; m_pronto = 0; m_erro = 0;
    end else begin
      m_obs = m_s2;
      m_s2 = m_s1;
      m_s1 = botoes;
      m_pronto = 0;
      m_erro = 0;
      m_load = 0;
      if (m_pending) begin
        m_pending = 0;
        m_blocked = 1;
        m_zero_len = 0;
        if ($countones(m_run_val) == 1) begin
          if (habilita) begin
            m_quad = m_run_val;
            m_pronto = 1;
            m_load = 1;
          end
        end else begin
          m_erro = 1;
        end
      end else if (m_blocked) begin
        if (m_obs == 0) m_zero_len++;
        else m_zero_len = 0;
        if (m_zero_len == D) begin
          m_blocked = 0;
          m_run_len = 0;
        end
      end else begin
        if (m_obs == 0) m_run_len = 0;
        else if (m_run_len > 0 && m_obs == m_run_val) m_run_len++;
        else begin
          m_run_val = m_obs;
          m_run_len = 1;
        end
        if (m_run_len == D + 1) m_pending = 1;
      end
      if (limpa && !m_load) m_quad = 0;
    end
    m_estado = m_blocked ? SOLTAR : m_pending ? DECIDE : (m_run_len > 0) ? ESTABILIZA : ESPERA;
  endtask

  // Compare process: model advances on the active edge, outputs are checked
  // on the falling edge.
  initial begin
    forever begin
      @(posedge clock);
      ciclo++;
      modelo_passo();
      @(negedge clock);
      check("quadrante", 32'(quadrante), 32'(m_quad));
      check("pronto", 32'(pronto), 32'(m_pronto));
      check("erro", 32'(erro), 32'(m_erro));
      check("db_estado", 32'(db_estado), 32'(m_estado));
      if (pronto) begin
        n_pronto++;
        $display("cycle %0d: pronto quadrante=%09b", ciclo, quadrante);
      end
      if (erro) begin
        n_erro++;
        $display("cycle %0d: erro (multi-button press)", ciclo);
      end
    end
  end

  task automatic espera_decisao();
    repeat (D + 4) @(posedge clock);
    @(negedge clock);
  endtask

  initial begin
    int n0, e0, dur, r;
    reset = 1'b1; botoes = 9'h1FF; habilita = 1'b1; limpa = 1'b0;

    // 1: reset with all buttons held, then one erro after release of reset
    repeat (3) @(posedge clock);
    @(negedge clock);
    check("t1_quad_reset", 32'(quadrante), 32'h0);
    reset = 1'b0;
    espera_decisao();
    check("t1_erro", 32'(erro), 32'h1);
    check("t1_quad", 32'(quadrante), 32'h0);
    botoes = 9'h000;
    repeat (10) @(negedge clock);

    // 2: single clean press
    n0 = n_pronto;
    botoes = 9'b000010000;
    espera_decisao();
    check("t2_pronto", 32'(pronto), 32'h1);
    check("t2_quad", 32'(quadrante), 32'h010);
    repeat (12) @(negedge clock);
    botoes = 9'h000;
    repeat (10) @(negedge clock);
    check("t2_pulsos", 32'(n_pronto - n0), 32'h1);
    check("t2_quad_keep", 32'(quadrante), 32'h010);

    // 3: bouncing then stable
    n0 = n_pronto;
    for (int i = 0; i < 6; i++) begin
      botoes = (i % 2 == 0) ? 9'h004 : 9'h000;
      repeat (2) @(negedge clock);
    end
    check("t3_bounce", 32'(n_pronto - n0), 32'h0);
    botoes = 9'h004;
    espera_decisao();
    check("t3_pronto", 32'(pronto), 32'h1);
    check("t3_quad", 32'(quadrante), 32'h004);
    repeat (6) @(negedge clock);
    botoes = 9'h000;
    repeat (10) @(negedge clock);
    check("t3_pulsos", 32'(n_pronto - n0), 32'h1);

    // 4: two buttons together
    n0 = n_pronto; e0 = n_erro;
    botoes = 9'b000000011;
    espera_decisao();
    check("t4_erro", 32'(erro), 32'h1);
    check("t4_quad", 32'(quadrante), 32'h004);
    repeat (4) @(negedge clock);
    botoes = 9'h000;
    repeat (10) @(negedge clock);
    check("t4_pronto", 32'(n_pronto - n0), 32'h0);
    check("t4_erros", 32'(n_erro - e0), 32'h1);

    // 5: direct switch without release is ignored
    n0 = n_pronto;
    botoes = 9'b000000001;
    espera_decisao();
    check("t5_pronto1", 32'(pronto), 32'h1);
    check("t5_quad1", 32'(quadrante), 32'h001);
    repeat (2) @(negedge clock);
    botoes = 9'b100000000;
    repeat (12) @(negedge clock);
    check("t5_ignored", 32'(n_pronto - n0), 32'h1);
    check("t5_quad_keep", 32'(quadrante), 32'h001);
    botoes = 9'h000;
    repeat (D) @(negedge clock);
    botoes = 9'b100000000;
    espera_decisao();
    check("t5_pronto2", 32'(pronto), 32'h1);
    check("t5_quad2", 32'(quadrante), 32'h100);
    repeat (4) @(negedge clock);
    botoes = 9'h000;
    repeat (10) @(negedge clock);

    // 6: habilita=0, limpa, limpa coincident with a load
    n0 = n_pronto;
    habilita = 1'b0;
    botoes = 9'b001000000;
    repeat (12) @(negedge clock);
    check("t6_disabled", 32'(n_pronto - n0), 32'h0);
    check("t6_quad_keep", 32'(quadrante), 32'h100);
    botoes = 9'h000;
    repeat (10) @(negedge clock);
    habilita = 1'b1;
    limpa = 1'b1;
    @(negedge clock);
    limpa = 1'b0;
    check("t6_limpa", 32'(quadrante), 32'h0);
    botoes = 9'b001000000;
    repeat (D + 3) @(posedge clock);
    @(negedge clock);
    limpa = 1'b1;
    @(negedge clock);
    limpa = 1'b0;
    check("t6_load_pronto", 32'(pronto), 32'h1);
    check("t6_load_quad", 32'(quadrante), 32'h040);
    repeat (4) @(negedge clock);
    botoes = 9'h000;
    repeat (10) @(negedge clock);

    // Random activity
    for (int s = 0; s < 300; s++) begin
      r = $urandom_range(0, 9);
      if (r < 3) botoes = 9'h000;
      else if (r < 8) botoes = 9'(1 << $urandom_range(0, 8));
      else botoes = 9'($urandom);
      habilita = ($urandom_range(0, 7) != 0);
      limpa = ($urandom_range(0, 15) == 0);
      reset = ($urandom_range(0, 63) == 0);
      dur = $urandom_range(1, 12);
      @(negedge clock);
      limpa = 1'b0;
      reset = 1'b0;
      repeat (dur - 1) @(negedge clock);
    end
    botoes = 9'h000;
    repeat (12) @(negedge clock);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
